// File: rtl/key_cond_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package key_cond_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } key_state_e;

  // 20 ms debounce and 1 s long-press at 50 MHz.
  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int LONG_CYCLES_DEF     = 50_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit; reset loads RST_VAL into both stages.
module sync_2ff #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_conditioner.sv
// Push-button synchroniser, debouncer and press/release/long-press strobe generator.
// Long-press support is compiled in only when KEY_COND_LONG_PRESS_EN is defined.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic pressed_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic long_press_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  // Synchroniser resets to the released pin level so a key held through reset reads as a new press.
  localparam bit KEY_IDLE_LVL = KEY_ACTIVE_LOW;

  logic key_sync;
  logic k_s;

  sync_2ff #(
    .RST_VAL(KEY_IDLE_LVL)
  ) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (key_i),
    .q_o   (key_sync)
  );

  assign k_s = KEY_ACTIVE_LOW ? ~key_sync : key_sync;

  key_state_e    state_d, state_q;
  logic [DW-1:0] deb_cnt_d, deb_cnt_q;
  logic          press_d, press_q;
  logic          release_d, release_q;
  logic          pressed_d, pressed_q;

  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (k_s) begin
          state_d   = DEB_PRESS;
          deb_cnt_d = '0;
        end
      end
      DEB_PRESS: begin
        if (!k_s) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = PRESSED;
          deb_cnt_d = '0;
          press_d   = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!k_s) begin
          state_d   = DEB_RELEASE;
          deb_cnt_d = '0;
        end
      end
      DEB_RELEASE: begin
        if (k_s) begin
          state_d   = PRESSED;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
          release_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        deb_cnt_d = '0;
      end
    endcase
    pressed_d = (state_d == PRESSED) || (state_d == DEB_RELEASE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      deb_cnt_q <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      pressed_q <= pressed_d;
    end
  end

  assign pressed_o       = pressed_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;

`ifdef KEY_COND_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] hold_d, hold_q;
  logic          long_d, long_q;

  // Hold time only advances in PRESSED; a release bounce freezes it, saturation stops repeats.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (press_d) begin
      hold_d = '0;
    end else if ((state_q == PRESSED) && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + 1'b1;
      long_d = (hold_q == HOLD_LAST);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_press_o = long_q;
`else
  logic unused_long_cfg;
  assign unused_long_cfg = (LONG_CYCLES > DEBOUNCE_CYCLES);
  assign long_press_o    = 1'b0;
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner with a run-length reference model of the debouncer.
module tb_key_conditioner;

  localparam int D = 4;
  localparam int L = 20;
`ifdef KEY_COND_LONG_PRESS_EN
  localparam int EXP_LONG_EDGE = 27;
`else
  localparam int EXP_LONG_EDGE = -1;
`endif

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  logic key_i = 1'b1;
  logic pressed_o, press_pulse_o, release_pulse_o, long_press_o;

  int errors = 0;
  int checks = 0;

  // Reference model: raw-pin history, accepted level, run of disagreeing samples, hold time.
  logic m_s1, m_s2;
  bit   m_acc;
  int   m_run;
  int   m_hold;
  bit   m_long_done;
  bit   e_press, e_release, e_long;

  key_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .key_i          (key_i),
    .pressed_o      (pressed_o),
    .press_pulse_o  (press_pulse_o),
    .release_pulse_o(release_pulse_o),
    .long_press_o   (long_press_o)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_s1 = 1'b1;
    m_s2 = 1'b1;
    m_acc = 1'b0;
    m_run = 0;
    m_hold = 0;
    m_long_done = 1'b1;
    e_press = 1'b0;
    e_release = 1'b0;
    e_long = 1'b0;
  endfunction

  // A level change is accepted once the synchronised key has disagreed with the
  // accepted level on D+1 consecutive edges; long press counts held edges after acceptance.
  function automatic void model_edge(input logic pin);
    bit ks;
`ifdef KEY_COND_LONG_PRESS_EN
    bit hold_edge;
    hold_edge = m_acc && (m_run == 0);
`endif
    ks = (m_s2 == 1'b0);
    e_press = 1'b0;
    e_release = 1'b0;
    e_long = 1'b0;
    m_s2 = m_s1;
    m_s1 = pin;
    if (ks != m_acc) m_run++;
    else m_run = 0;
    if (m_run == D + 1) begin
      m_acc = ks;
      m_run = 0;
      if (ks) begin
        e_press = 1'b1;
        m_hold = 0;
        m_long_done = 1'b0;
      end else begin
        e_release = 1'b1;
      end
    end
`ifdef KEY_COND_LONG_PRESS_EN
    if (hold_edge && !m_long_done) begin
      m_hold++;
      if (m_hold == L) begin
        e_long = 1'b1;
        m_long_done = 1'b1;
      end
    end
`endif
  endfunction

  task automatic cycle(input logic pin);
    @(negedge clk);
    key_i = pin;
    @(posedge clk);
    if (!rst_ni) model_reset();
    else model_edge(pin);
    #1;
  endtask

  task automatic test_reset();
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    if ({pressed_o, press_pulse_o, release_pulse_o, long_press_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async: got %b want 0000",
               {pressed_o, press_pulse_o, release_pulse_o, long_press_o});
    end
    checks++;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1);
      if ({pressed_o, press_pulse_o, release_pulse_o, long_press_o} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: got %b want 0000", i,
                 {pressed_o, press_pulse_o, release_pulse_o, long_press_o});
      end
      checks++;
    end
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1);
      if ({pressed_o, press_pulse_o, release_pulse_o, long_press_o} !==
          {m_acc, e_press, e_release, e_long}) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got %b want %b", i,
                 {pressed_o, press_pulse_o, release_pulse_o, long_press_o},
                 {m_acc, e_press, e_release, e_long});
      end
      checks++;
    end
  endtask

  task automatic test_clean_press();
    int press_edge = -1;
    int long_edge = -1;
    int rel_edge = -1;
    for (int i = 1; i <= 30; i++) begin
      cycle(1'b0);
      if (press_pulse_o === 1'b1) press_edge = i;
      if (long_press_o === 1'b1) long_edge = i;
      if ({pressed_o, press_pulse_o, release_pulse_o, long_press_o} !==
          {m_acc, e_press, e_release, e_long}) begin
        errors++;
        $display("FAIL clean_press cyc %0d: got %b want %b", i,
                 {pressed_o, press_pulse_o, release_pulse_o, long_press_o},
                 {m_acc, e_press, e_release, e_long});
      end
      checks++;
    end
    if (press_edge != 7) begin
      errors++;
      $display("FAIL clean_press_edge: got %0d want 7", press_edge);
    end
    checks++;
    if (long_edge != EXP_LONG_EDGE) begin
      errors++;
      $display("FAIL clean_long_edge: got %0d want %0d", long_edge, EXP_LONG_EDGE);
    end
    checks++;
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1);
      if (release_pulse_o === 1'b1) rel_edge = i;
      if ({pressed_o, press_pulse_o, release_pulse_o, long_press_o} !==
          {m_acc, e_press, e_release, e_long}) begin
        errors++;
        $display("FAIL clean_release cyc %0d: got %b want %b", i,
                 {pressed_o, press_pulse_o, release_pulse_o, long_press_o},
                 {m_acc, e_press, e_release, e_long});
      end
      checks++;
    end
    if (rel_edge != 7 || pressed_o !== 1'b0) begin
      errors++;
      $display("FAIL clean_release_edge: got edge %0d pressed %b want edge 7 pressed 0",
               rel_edge, pressed_o);
    end
    checks++;
  endtask

  task automatic test_bouncy_press();
    logic pat [13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                       1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int strobes = 0;
    int high_lvl = 0;
    for (int i = 0; i < 13; i++) begin
      cycle(pat[i]);
      strobes += int'(press_pulse_o) + int'(release_pulse_o) + int'(long_press_o);
      high_lvl += int'(pressed_o);
      if ({pressed_o, press_pulse_o, release_pulse_o, long_press_o} !==
          {m_acc, e_press, e_release, e_long}) begin
        errors++;
        $display("FAIL bouncy_press cyc %0d: got %b want %b", i,
                 {pressed_o, press_pulse_o, release_pulse_o, long_press_o},
                 {m_acc, e_press, e_release, e_long});
      end
      checks++;
    end
    if (strobes != 0 || high_lvl != 0) begin
      errors++;
      $display("FAIL bouncy_quiet: got strobes %0d pressed cycles %0d want 0 and 0",
               strobes, high_lvl);
    end
    checks++;
  endtask

  task automatic test_release_bounce();
    int rel_cnt = 0;
    int rel_edge = -1;
    for (int i = 0; i < 10; i++) cycle(1'b0);
    for (int i = 0; i < 12; i++) begin
      cycle((i < 2) ? 1'b1 : 1'b0);
      rel_cnt += int'(release_pulse_o) + int'(press_pulse_o);
      if ({pressed_o, press_pulse_o, release_pulse_o, long_press_o} !==
          {m_acc, e_press, e_release, e_long}) begin
        errors++;
        $display("FAIL release_bounce cyc %0d: got %b want %b", i,
                 {pressed_o, press_pulse_o, release_pulse_o, long_press_o},
                 {m_acc, e_press, e_release, e_long});
      end
      checks++;
    end
    if (rel_cnt != 0 || pressed_o !== 1'b1) begin
      errors++;
      $display("FAIL release_bounce_hold: got strobes %0d pressed %b want 0 and 1",
               rel_cnt, pressed_o);
    end
    checks++;
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1);
      if (release_pulse_o === 1'b1) rel_edge = i;
    end
    if (rel_edge != 7 || pressed_o !== 1'b0) begin
      errors++;
      $display("FAIL release_latency: got edge %0d pressed %b want edge 7 pressed 0",
               rel_edge, pressed_o);
    end
    checks++;
  endtask

  task automatic test_short_press();
    int n_press = 0;
    int n_rel = 0;
    int n_long = 0;
    for (int i = 0; i < 22; i++) begin
      cycle((i < 10) ? 1'b0 : 1'b1);
      n_press += int'(press_pulse_o);
      n_rel += int'(release_pulse_o);
      n_long += int'(long_press_o);
    end
    if (n_press != 1 || n_rel != 1 || n_long != 0) begin
      errors++;
      $display("FAIL short_press: got press %0d release %0d long %0d want 1 1 0",
               n_press, n_rel, n_long);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    int press_edge = -1;
    for (int i = 0; i < 5; i++) cycle(1'b0);
    rst_ni = 1'b0;
    model_reset();
    #1;
    if ({pressed_o, press_pulse_o, release_pulse_o, long_press_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_deb: got %b want 0000",
               {pressed_o, press_pulse_o, release_pulse_o, long_press_o});
    end
    checks++;
    cycle(1'b0);
    cycle(1'b0);
    rst_ni = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b0);
      if (press_pulse_o === 1'b1) press_edge = i;
    end
    if (press_edge != 7 || pressed_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_repress: got edge %0d pressed %b want edge 7 pressed 1",
               press_edge, pressed_o);
    end
    checks++;
    rst_ni = 1'b0;
    model_reset();
    #1;
    if (pressed_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_hold: got pressed %b want 0", pressed_o);
    end
    checks++;
    cycle(1'b1);
    rst_ni = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cycle(1'b1);
      if ({pressed_o, press_pulse_o, release_pulse_o, long_press_o} !==
          {m_acc, e_press, e_release, e_long}) begin
        errors++;
        $display("FAIL reset_mid_after cyc %0d: got %b want %b", i,
                 {pressed_o, press_pulse_o, release_pulse_o, long_press_o},
                 {m_acc, e_press, e_release, e_long});
      end
      checks++;
    end
  endtask

  task automatic test_random();
    logic lvl = 1'b1;
    int   left = 0;
    for (int i = 0; i < 600; i++) begin
      if (left == 0) begin
        lvl = ~lvl;
        left = ($urandom_range(0, 7) == 0) ? 30 : int'($urandom_range(1, 10));
      end
      left--;
      cycle(lvl);
      if ({pressed_o, press_pulse_o, release_pulse_o, long_press_o} !==
          {m_acc, e_press, e_release, e_long}) begin
        errors++;
        $display("FAIL random cyc %0d: got %b want %b", i,
                 {pressed_o, press_pulse_o, release_pulse_o, long_press_o},
                 {m_acc, e_press, e_release, e_long});
      end
      checks++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_press();
    test_bouncy_press();
    test_release_bounce();
    test_short_press();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
